// File: rtl/stream_mux_arb.sv
// N-to-1 valid/ready stream mux with round-robin or fixed-priority
// arbitration, optional packet lock and one registered output stage.
module stream_mux_arb #(
   parameter int N_CH     = 4,
   parameter int WIDTH    = 8,
   parameter int ARB_MODE = 1,
   parameter int PKT_LOCK = 1,
   parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   input  logic [N_CH-1:0]       in_last,
   output logic [N_CH-1:0]       in_ready,
   input  logic [N_CH-1:0]       chan_en,
   output logic [WIDTH-1:0]      out_data,
   output logic [CH_W-1:0]       out_chan,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready
);

   logic            load_en;
   logic            xfer;
   logic            locked;
   logic            found;
   logic            sel_last;
   logic [CH_W-1:0] lock_ch;
   logic [CH_W-1:0] ptr;
   logic [CH_W-1:0] gidx;
   logic [CH_W-1:0] nxt_ptr;
   logic [N_CH-1:0] lock_mask;
   logic [N_CH-1:0] elig;
   logic [N_CH-1:0] grant;
   logic [WIDTH-1:0] sel_data;
   int              base;
   int              idx;

   assign load_en = !out_valid || out_ready;

   // a held lock ignores chan_en so an open packet always completes
   always_comb begin
      lock_mask = '0;
      lock_mask[lock_ch] = 1'b1;
      elig = locked ? (lock_mask & in_valid) : (in_valid & chan_en);
   end

   always_comb begin
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      idx   = 0;
      base  = (ARB_MODE != 0) ? int'(ptr) : 0;
      for (int k = 0; k < N_CH; k++) begin
         idx = (base + k) % N_CH;
         if (!found && elig[idx]) begin
            grant[idx] = 1'b1;
            gidx       = CH_W'(idx);
            found      = 1'b1;
         end
      end
   end

   assign in_ready = grant & {N_CH{rst_n & load_en}};
   assign xfer     = |(in_valid & in_ready);
   assign sel_data = in_data[int'(gidx)*WIDTH +: WIDTH];
   assign sel_last = in_last[gidx];
   assign nxt_ptr  = CH_W'((int'(gidx) + 1) % N_CH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         out_last  <= 1'b0;
      end else if (load_en) begin
         out_valid <= xfer;
         if (xfer) begin
            out_data <= sel_data;
            out_chan <= gidx;
            out_last <= sel_last;
         end
      end
   end

   // ptr only advances when the winner gives up ownership
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked  <= 1'b0;
         lock_ch <= '0;
         ptr     <= '0;
      end else if (xfer) begin
         if (PKT_LOCK != 0) begin
            locked  <= !sel_last;
            lock_ch <= gidx;
         end
         if (PKT_LOCK == 0 || sel_last) begin
            ptr <= nxt_ptr;
         end
      end
   end

endmodule
